lut_config_loader: RTL
======================

// Module: lut_config_loader
// PURPOSE
//  - Bit-serial configuration loader sitting directly upstream of the LUT array.
//  - Receives a bitstream of NUM_LUTS 16-bit truth tables followed by a 16-bit XOR checksum.
//  - Commits the tables atomically to the LUT in1 buses, then drives the LUT mode pins:
//    prgm_b=1 and CLB_prgm_b=0 enable evaluation.
//  - While loading, or after a failed load, the LUTs are held non-evaluating (output x).
// PARAMETERS
//  - NUM_LUTS   default 4   number of LUTs configured; lut_cfg width = NUM_LUTS*16
//  - LUT_WIDTH  default 16  truth-table bits per LUT; fixed at 16, from the package
// PORTS
//  - clk         in   1              single clock, rising edge
//  - rst_n       in   1              asynchronous, active-low reset
//  - start       in   1              1-cycle pulse: begin a new load
//  - cfg_bit     in   1              serial config data
//  - cfg_valid   in   1              cfg_bit is valid this cycle
//  - cfg_ready   out  1              loader accepts a bit this cycle
//  - lut_cfg     out  NUM_LUTS*16    committed tables; LUT k uses bits [16k+15:16k]
//  - prgm_b      out  1              to the LUT prgm_b pin
//  - clb_prgm_b  out  1              to the LUT CLB_prgm_b pin
//  - busy        out  1              load in progress
//  - done        out  1              level: last load committed successfully
//  - err         out  1              level: last load failed its checksum
// BEHAVIOUR
//  - Reset values (async, rst_n=0):
//    lut_cfg=0, shadow=0, prgm_b=0, clb_prgm_b=1, cfg_ready=0, busy=0, done=0, err=0, state=IDLE.
//  - Transfer: a bit is accepted on a rising edge where cfg_valid && cfg_ready.
//    cfg_valid may drop for any number of cycles; nothing advances during gaps.
//  - Bit order: word 0 first, each word LSB first. Checksum is LSB first, after the last word.
//  - FSM:
//    - IDLE: cfg_ready=0.
//      start -> LOAD. On entry: busy=1, done=0, err=0, prgm_b=0, clb_prgm_b=1,
//      bit_cnt=0, word_cnt=0, running XOR=0.
//    - LOAD: cfg_ready=1. Accepted bits go into shadow[16*word_cnt + bit_cnt].
//      - bit_cnt wraps 15->0 and increments word_cnt.
//      - When the running XOR absorbs the completed word and word_cnt wraps from NUM_LUTS-1 -> CHECK.
//    - CHECK: cfg_ready=1. Sixteen accepted bits form the received checksum.
//      After the 16th bit -> VERIFY.
//    - VERIFY: cfg_ready=0, one cycle.
//      - Match -> COMMIT.
//      - Mismatch -> FAIL: err=1, busy=0. lut_cfg is unchanged; prgm_b=1, clb_prgm_b=1, so LUTs stay disabled.
//    - COMMIT: one cycle. lut_cfg <= shadow -> RUN.
//    - RUN: prgm_b=1, clb_prgm_b=0, done=1, busy=0, cfg_ready=0.
//  - Latency: last checksum bit accepted at edge N. VERIFY is cycle N+1. lut_cfg updates at edge N+2.
//    prgm_b/clb_prgm_b/done take their RUN values from edge N+3, one cycle after lut_cfg,
//    so LUTs never evaluate a half-written table.
//  - start in LOAD/CHECK/VERIFY/COMMIT: ignored. start in RUN or FAIL: restart as from IDLE.
//    prgm_b drops to 0 on the same edge, and the previous lut_cfg is held until the next COMMIT.
//  - start coinciding with an accepted bit in RUN/FAIL: cfg_ready is 0, so no bit is consumed.
//  - rst_n low mid-load: everything returns to its reset value immediately. The partial shadow is discarded.
//  - Widths: bit_cnt 4 bits; word_cnt $clog2(NUM_LUTS)+1 bits; checksum and running XOR 16 bits.
//  - All outputs are registered; no combinational input-to-output path.
// STRUCTURE
//  - Package cfg_pkg: LUT_WIDTH=16, state enum {IDLE,LOAD,CHECK,VERIFY,COMMIT,RUN,FAIL},
//    pin constants PRGM_ACTIVE=1'b1, CLB_EVAL=1'b0.
//  - Sub-module cfg_shift_word: 16-bit LSB-first deserialiser with bit counter and word_done strobe.
//    Instantiated once; reused for data words and for the checksum.
//  - Top: FSM, word counter, running XOR, shadow array, commit register, LUT pin drivers.
// TESTING (NUM_LUTS=2 unless stated)
//  - Reset check: hold rst_n=0 -> all outputs at their reset values; pulse start with rst_n=0 -> no change.
//  - Good load: start, then 16'hA5C3, 16'h0F0F, checksum 16'hAACC with cfg_valid=1 every cycle
//    -> lut_cfg=32'h0F0FA5C3. done=1, prgm_b=1, clb_prgm_b=0 exactly one cycle after lut_cfg updates.
//  - Bad checksum: same words, checksum 16'hAACD -> err=1, done=0, lut_cfg=0,
//    prgm_b=1, clb_prgm_b=1, cfg_ready=0.
//  - Backpressure: good load with cfg_valid toggling 1,0,0,1 in a random gap pattern
//    -> identical lut_cfg. cfg_ready stays 1 throughout LOAD and CHECK.
//  - Mid-load events:
//    - start pulses during LOAD are ignored (word_cnt and shadow undisturbed).
//    - rst_n=0 after 20 bits -> reset values. A following good load succeeds.
//  - Reload from RUN: after a good load, start and load 16'hFFFF, 16'h0001, checksum 16'hFFFE
//    -> prgm_b=0 during the load, old lut_cfg held, new lut_cfg=32'h0001FFFF on commit.

Source files
------------

// File: rtl/lut_config_loader_pkg.sv
// Shared types and constants for the LUT configuration loader.
// Pin constants name the LUT mode-pin levels that enable evaluation.
package cfg_pkg;
  localparam int LUT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    VERIFY,
    COMMIT,
    RUN,
    FAIL
  } state_t;

  localparam logic PRGM_ACTIVE = 1'b1;
  localparam logic CLB_EVAL    = 1'b0;
endpackage

// File: rtl/lut_config_loader_shift_word.sv
// 16-bit LSB-first deserialiser. word presents the completed word in the
// same cycle as word_done, so the caller can capture it without a bubble.
module cfg_shift_word
  import cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 bit_in,
  input  logic                 bit_en,
  output logic [3:0]           bit_cnt,
  output logic [LUT_WIDTH-1:0] word,
  output logic                 word_done
);
  logic [LUT_WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (bit_en) begin
      sr      <= {bit_in, sr[LUT_WIDTH-1:1]};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  assign word      = {bit_in, sr[LUT_WIDTH-1:1]};
  assign word_done = bit_en && (bit_cnt == 4'hF);
endmodule

// File: rtl/lut_config_loader.sv
// Bit-serial LUT configuration loader: deserialises NUM_LUTS truth tables plus
// an XOR checksum, commits them atomically, then enables LUT evaluation.
module lut_config_loader
  import cfg_pkg::*;
#(
  parameter int NUM_LUTS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          cfg_bit,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  output logic [NUM_LUTS*LUT_WIDTH-1:0] lut_cfg,
  output logic                          prgm_b,
  output logic                          clb_prgm_b,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);
  localparam int WCW = $clog2(NUM_LUTS) + 1;

  state_t state, state_n;
  logic [WCW-1:0]                         word_cnt;
  logic [LUT_WIDTH-1:0]                   run_xor, chk_rx;
  logic [NUM_LUTS-1:0][LUT_WIDTH-1:0]     shadow;
  logic [3:0]                             bit_cnt;
  logic [LUT_WIDTH-1:0]                   word;
  logic                                   word_done;
  logic                                   restart, accept, last_word;

  assign restart   = start && (state == IDLE || state == RUN || state == FAIL);
  assign accept    = cfg_valid && cfg_ready;
  assign last_word = (word_cnt == WCW'(NUM_LUTS - 1));

  cfg_shift_word u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (restart),
    .bit_in    (cfg_bit),
    .bit_en    (accept),
    .bit_cnt   (bit_cnt),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, RUN, FAIL: if (start) state_n = LOAD;
      LOAD:            if (word_done && last_word) state_n = CHECK;
      CHECK:           if (word_done) state_n = VERIFY;
      VERIFY:          state_n = (chk_rx == run_xor) ? COMMIT : FAIL;
      COMMIT:          state_n = RUN;
      default:         state_n = IDLE;
    endcase
  end

  // Mode pins lag the commit by a cycle so the LUTs never see a half-written table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_cfg    <= '0;
      shadow     <= '0;
      prgm_b     <= 1'b0;
      clb_prgm_b <= 1'b1;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= '0;
      run_xor    <= '0;
      chk_rx     <= '0;
    end else begin
      cfg_ready <= (state_n == LOAD) || (state_n == CHECK);
      if (restart) begin
        busy       <= 1'b1;
        done       <= 1'b0;
        err        <= 1'b0;
        prgm_b     <= ~PRGM_ACTIVE;
        clb_prgm_b <= ~CLB_EVAL;
        word_cnt   <= '0;
        run_xor    <= '0;
      end else begin
        case (state)
          LOAD: if (accept) begin
            for (int k = 0; k < NUM_LUTS; k++)
              if (word_cnt == WCW'(k)) shadow[k][bit_cnt] <= cfg_bit;
            if (word_done) begin
              run_xor  <= run_xor ^ word;
              word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            end
          end
          CHECK: if (word_done) chk_rx <= word;
          VERIFY: if (state_n == FAIL) begin
            err        <= 1'b1;
            busy       <= 1'b0;
            prgm_b     <= PRGM_ACTIVE;
            clb_prgm_b <= ~CLB_EVAL;
          end
          COMMIT: lut_cfg <= shadow;
          RUN: begin
            prgm_b     <= PRGM_ACTIVE;
            clb_prgm_b <= CLB_EVAL;
            done       <= 1'b1;
            busy       <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
